// File: rtl/isp_restart_pkg.sv
// Shared types and helpers for the post-ISP restart sequencer.
package isp_restart_pkg;

  localparam int KEY_W   = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_HOLD  = 3'd2,
    S_FIRE  = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_set_idx(input logic [MAX_REQ-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/isp_prio_enc.sv
// Lowest-index-wins priority encoder used to arbitrate restart requests.
module isp_prio_enc
  import isp_restart_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     vec,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [MAX_REQ-1:0] vec_ext;

  assign vec_ext = MAX_REQ'(vec);
  assign valid   = |vec;
  assign idx     = IDX_W'(lowest_set_idx(vec_ext));

endmodule

// File: rtl/isp_restart_seq.sv
// Restart sequencer run after an ISP update: arbitrates request sources,
// demands a confirmation key, waits a hold-off, then drives a timed
// active-low restart pulse from a flop.
module isp_restart_seq
  import isp_restart_pkg::*;
#(
  parameter int               N_REQ       = 2,
  parameter int               CNT_W       = 24,
  parameter int               HOLDOFF     = 1000000,
  parameter int               ARM_TIMEOUT = 2000000,
  parameter int               PULSE_CYC   = 16,
  parameter logic [KEY_W-1:0] KEY         = 8'hA5
) (
  input  logic                                   CLK,
  input  logic                                   RESETn,
  input  logic [N_REQ-1:0]                       req_i,
  input  logic                                   key_valid_i,
  input  logic [KEY_W-1:0]                       key_i,
  input  logic                                   abort_i,
  input  logic                                   err_clr_i,
  output logic                                   restart_n_o,
  output logic                                   busy_o,
  output logic [2:0]                             state_o,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] src_o,
  output logic                                   err_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Reject parameter sets the counter cannot represent.
  if (N_REQ < 1 || N_REQ > MAX_REQ ||
      HOLDOFF < 1 || ARM_TIMEOUT < 1 || PULSE_CYC < 1 ||
      longint'(HOLDOFF)     >= (longint'(1) << CNT_W) ||
      longint'(ARM_TIMEOUT) >= (longint'(1) << CNT_W) ||
      longint'(PULSE_CYC)   >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("isp_restart_seq: N_REQ/HOLDOFF/ARM_TIMEOUT/PULSE_CYC out of range");
  end

  state_t             state;
  logic [N_REQ-1:0]   req_q;
  logic [N_REQ-1:0]   rise;
  logic               rise_vld;
  logic [IDX_W-1:0]   rise_idx;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic               key_ok;

  assign rise     = req_i & ~req_q;
  assign cnt_zero = (cnt == '0);
  assign key_ok   = key_valid_i && (key_i == KEY);
  assign state_o  = state;

  isp_prio_enc #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec   (rise),
    .valid (rise_vld),
    .idx   (rise_idx)
  );

  // Sequencer FSM with its shared down-counter and all registered outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      req_q       <= '0;
      src_o       <= '0;
      err_o       <= 1'b0;
      restart_n_o <= 1'b1;
      busy_o      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here; a later assignment to
      // the same flop in this block overrides an earlier one, which is how an
      // error set beats a simultaneous err_clr_i below.
      req_q <= req_i;
      if (err_clr_i) err_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rise_vld) begin
            state  <= S_ARMED;
            busy_o <= 1'b1;
            src_o  <= rise_idx;
            cnt    <= CNT_W'(ARM_TIMEOUT - 1);
          end
        end

        S_ARMED: begin
          if (abort_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else if (key_ok) begin
            state <= S_HOLD;
            cnt   <= CNT_W'(HOLDOFF - 1);
          end else if (key_valid_i || cnt_zero) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            err_o  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (abort_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else if (cnt_zero) begin
            state       <= S_FIRE;
            cnt         <= CNT_W'(PULSE_CYC - 1);
            restart_n_o <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // Once the pulse has started it always runs to completion.
        S_FIRE: begin
          if (cnt_zero) begin
            state       <= S_LOCK;
            restart_n_o <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // Every source must drop before a new sequence can start.
        S_LOCK: begin
          if (req_i == '0) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state       <= S_IDLE;
          busy_o      <= 1'b0;
          restart_n_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isp_restart_seq.sv
// Directed, table-driven bench for isp_restart_seq with short bench timings.
module tb_isp_restart_seq;

  localparam int         N_REQ       = 2;
  localparam int         CNT_W       = 24;
  localparam int         HOLDOFF     = 10;
  localparam int         ARM_TIMEOUT = 20;
  localparam int         PULSE_CYC   = 4;
  localparam logic [7:0] KEY         = 8'hA5;
  localparam logic [7:0] BAD         = 8'h5A;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic [1:0] req;
  logic       key_valid;
  logic [7:0] key;
  logic       abort;
  logic       err_clr;
  logic       restart_n;
  logic       busy;
  logic [2:0] state;
  logic [0:0] src;
  logic       err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  isp_restart_seq #(
    .N_REQ       (N_REQ),
    .CNT_W       (CNT_W),
    .HOLDOFF     (HOLDOFF),
    .ARM_TIMEOUT (ARM_TIMEOUT),
    .PULSE_CYC   (PULSE_CYC),
    .KEY         (KEY)
  ) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .req_i       (req),
    .key_valid_i (key_valid),
    .key_i       (key),
    .abort_i     (abort),
    .err_clr_i   (err_clr),
    .restart_n_o (restart_n),
    .busy_o      (busy),
    .state_o     (state),
    .src_o       (src),
    .err_o       (err)
  );

  // Inputs held for n rising edges, then outputs compared 1 time unit later.
  typedef struct {
    logic [1:0] req;
    logic       kv;
    logic [7:0] key;
    logic       abort;
    logic       clr;
    int         n;
    logic [2:0] st;
    logic       rn;
    logic       src;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] r, input logic kv, input logic [7:0] k,
                              input logic ab, input logic cl, input int n,
                              input logic [2:0] st, input logic rn, input logic s,
                              input logic e);
    vec_t v;
    v.req = r;  v.kv = kv; v.key = k; v.abort = ab; v.clr = cl; v.n = n;
    v.st  = st; v.rn = rn; v.src = s; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic kv, input logic [7:0] k,
                       input logic ab, input logic cl);
    req = r; key_valid = kv; key = k; abort = ab; err_clr = cl;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic rn,
                           input logic s, input logic e);
    check({tag, ".state"},     32'(state),     32'(st));
    check({tag, ".restart_n"}, 32'(restart_n), 32'(rn));
    check({tag, ".busy"},      32'(busy),      32'(st != 3'd0));
    check({tag, ".src"},       32'(src),       32'(s));
    check({tag, ".err"},       32'(err),       32'(e));
  endtask

  task automatic add_nominal();
    // Rise on source 1 at edge e, key at e+3 (= j), pulse low j+10..j+13.
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 1,  3'd1, 1, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 2,  3'd1, 1, 1, 0));
    tbl.push_back(mk(2'b10, 1, KEY, 0, 0, 1,  3'd2, 1, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 9,  3'd2, 1, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 1,  3'd3, 0, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 3,  3'd3, 0, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 1,  3'd4, 1, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 3,  3'd4, 1, 1, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0, 1,  3'd0, 1, 1, 0));
  endtask

  initial begin
    RESETn = 1'b0;
    drive(2'b00, 0, 8'h00, 0, 0);
    #12;
    check_all("reset", 3'd0, 1, 0, 0);
    RESETn = 1'b1;
    step(1);
    check_all("post_reset", 3'd0, 1, 0, 0);

    add_nominal();
    // Arbitration: simultaneous rise -> lowest index; held-high does not re-arm.
    tbl.push_back(mk(2'b11, 0, 0,   0, 0, 1,  3'd1, 1, 0, 0));
    tbl.push_back(mk(2'b11, 0, 0,   1, 0, 1,  3'd0, 1, 0, 0));
    tbl.push_back(mk(2'b11, 0, 0,   0, 0, 2,  3'd0, 1, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0, 1,  3'd0, 1, 0, 0));
    // Second rise while ARMED ignored; abort beats a valid key.
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 1,  3'd1, 1, 1, 0));
    tbl.push_back(mk(2'b11, 0, 0,   0, 0, 1,  3'd1, 1, 1, 0));
    tbl.push_back(mk(2'b11, 1, KEY, 1, 0, 1,  3'd0, 1, 1, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0, 1,  3'd0, 1, 1, 0));
    // Wrong key: error, no pulse, then clear.
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 1,  3'd1, 1, 1, 0));
    tbl.push_back(mk(2'b10, 1, BAD, 0, 0, 1,  3'd0, 1, 1, 1));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 5,  3'd0, 1, 1, 1));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 1,  3'd0, 1, 1, 1));
    tbl.push_back(mk(2'b10, 0, 0,   0, 1, 1,  3'd0, 1, 1, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0, 1,  3'd0, 1, 1, 0));
    // Arm timeout: ARMED for exactly 20 edges.
    tbl.push_back(mk(2'b01, 0, 0,   0, 0, 1,  3'd1, 1, 0, 0));
    tbl.push_back(mk(2'b01, 0, 0,   0, 0, 19, 3'd1, 1, 0, 0));
    tbl.push_back(mk(2'b01, 0, 0,   0, 0, 1,  3'd0, 1, 0, 1));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0, 1,  3'd0, 1, 0, 1));
    tbl.push_back(mk(2'b00, 0, 0,   0, 1, 1,  3'd0, 1, 0, 0));
    // Set and clear in the same cycle: set wins.
    tbl.push_back(mk(2'b01, 0, 0,   0, 0, 1,  3'd1, 1, 0, 0));
    tbl.push_back(mk(2'b01, 1, BAD, 0, 1, 1,  3'd0, 1, 0, 1));
    tbl.push_back(mk(2'b01, 0, 0,   0, 1, 1,  3'd0, 1, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0, 1,  3'd0, 1, 0, 0));
    // Abort in HOLD with counter at 5: no pulse follows.
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 1,  3'd1, 1, 1, 0));
    tbl.push_back(mk(2'b10, 1, KEY, 0, 0, 1,  3'd2, 1, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 4,  3'd2, 1, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,   1, 0, 1,  3'd0, 1, 1, 0));
    tbl.push_back(mk(2'b10, 0, 0,   0, 0, 12, 3'd0, 1, 1, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0, 1,  3'd0, 1, 1, 0));
    // Abort and key during FIRE are ignored; pulse still 4 cycles.
    tbl.push_back(mk(2'b01, 0, 0,   0, 0, 1,  3'd1, 1, 0, 0));
    tbl.push_back(mk(2'b01, 1, KEY, 0, 0, 1,  3'd2, 1, 0, 0));
    tbl.push_back(mk(2'b01, 0, 0,   0, 0, 10, 3'd3, 0, 0, 0));
    tbl.push_back(mk(2'b01, 1, KEY, 1, 0, 3,  3'd3, 0, 0, 0));
    tbl.push_back(mk(2'b01, 0, 0,   0, 0, 1,  3'd4, 1, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0, 1,  3'd0, 1, 0, 0));
    // Back-to-back: second full sequence with identical timing.
    add_nominal();

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].kv, tbl[i].key, tbl[i].abort, tbl[i].clr);
      step(tbl[i].n);
      check_all($sformatf("v%0d", i), tbl[i].st, tbl[i].rn, tbl[i].src, tbl[i].err);
    end

    // Reset asserted during the second FIRE cycle releases restart at once.
    drive(2'b10, 0, 8'h00, 0, 0);
    step(1);
    drive(2'b10, 1, KEY, 0, 0);
    step(1);
    drive(2'b10, 0, 8'h00, 0, 0);
    step(HOLDOFF);
    check_all("rst.fire1", 3'd3, 0, 1, 0);
    step(1);
    check_all("rst.fire2", 3'd3, 0, 1, 0);
    #2;
    RESETn = 1'b0;
    #1;
    check_all("rst.async", 3'd0, 1, 0, 0);
    drive(2'b00, 0, 8'h00, 0, 0);
    step(2);
    #2;
    RESETn = 1'b1;
    step(PULSE_CYC + HOLDOFF + 6);
    check_all("rst.after", 3'd0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/isp_restart_seq.md
Name: isp_restart_seq

Overview:
- Parametrised restart sequencer that follows an In-System-Programming update.
- Accepts N_REQ restart-request sources (MSS GPIO, fabric ISP agents). Requires a confirmation key, then waits a programmable hold-off and issues a timed active-low restart pulse.
- Sits beside the MSS subsystem block. It is clocked by the fabric CCC global and reset by power-on reset.
- Adds behaviour the single-purpose restart block lacks: multi-source arbitration, key confirmation, arm timeout, abort, lockout and status.

Parameters:
- N_REQ, 2, number of request sources (1..8).
- CNT_W, 24, width of the hold-off/timeout counter.
- HOLDOFF, 1000000, cycles between key acceptance and restart assertion (1..2^CNT_W-1).
- ARM_TIMEOUT, 2000000, cycles ARMED waits for a key before giving up (1..2^CNT_W-1).
- PULSE_CYC, 16, cycles restart_n_o is held low (>=1).
- KEY, 8'hA5, confirmation key value.

Ports:
- CLK  in  1  system clock.
- RESETn  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  level restart requests, synchronous to CLK; a rising edge triggers.
- key_valid_i  in  1  key strobe, one cycle.
- key_i  in  8  key value, qualified by key_valid_i.
- abort_i  in  1  cancel request, synchronous.
- err_clr_i  in  1  clears err_o.
- restart_n_o  out  1  registered active-low restart pulse.
- busy_o  out  1  high in any state other than IDLE.
- state_o  out  3  encoded state: IDLE=0, ARMED=1, HOLD=2, FIRE=3, LOCK=4.
- src_o  out  max(1,$clog2(N_REQ))  index of the source that won arbitration.
- err_o  out  1  sticky: wrong key or arm timeout.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low. Clock: CLK. Reset: RESETn.
  - While reset is asserted: state=IDLE, restart_n_o=1, busy_o=0, src_o=0, err_o=0, counter=0, req_q=0.
  - Reset asserted mid-FIRE releases restart_n_o high immediately.
- Edge detect: rise = req_i & ~req_q, where req_q is registered every cycle in every state.
- IDLE:
  - If rise is nonzero: go to ARMED on the same edge. src_o latches the lowest set index of rise. counter loads ARM_TIMEOUT-1.
  - Multiple simultaneous rises: the lowest index wins; the others are dropped.
- ARMED, priority order:
  - abort_i: go to IDLE.
  - key_valid_i with key_i==KEY: go to HOLD, counter loads HOLDOFF-1.
  - key_valid_i with wrong key: go to IDLE, err_o=1.
  - counter==0: go to IDLE, err_o=1 (timeout).
  - Otherwise: counter decrements.
- HOLD:
  - abort_i: go to IDLE.
  - counter==0: go to FIRE, counter loads PULSE_CYC-1, restart_n_o=0.
  - Otherwise: counter decrements.
- FIRE:
  - Not abortable; key_valid_i and abort_i are ignored.
  - counter==0: go to LOCK, restart_n_o=1.
  - Otherwise: counter decrements.
- LOCK: stays until req_i==0 for one sampled cycle, then goes to IDLE. A source must release before it can re-trigger.
- Request edges arriving outside IDLE are ignored and are not queued.
- Timing:
  - Key accepted at edge j: restart_n_o falls at edge j+HOLDOFF and rises at edge j+HOLDOFF+PULSE_CYC.
  - Exactly PULSE_CYC low cycles; glitch-free, driven from a flop.
- err_o:
  - Set by a wrong key or a timeout; cleared by err_clr_i.
  - If set and clear occur in the same cycle, set wins.
- Counter: unsigned, CNT_W bits; never wraps, because every load is followed by a decrement to 0.
- Parameter check: elaboration-time assertion that HOLDOFF, ARM_TIMEOUT and PULSE_CYC are >=1 and fit in CNT_W.

Decomposition:
- Package isp_restart_pkg holds:
  - the state enum (3-bit encoding as above);
  - localparam KEY_W=8;
  - a function returning the lowest-set-bit index.
- Sub-module isp_prio_enc (parametric lowest-index priority encoder, N_REQ inputs, valid + index out). It is used for arbitration.
- Sequencer FSM and counter live in isp_restart_seq.

Test Plan:
Bench parameters: N_REQ=2, HOLDOFF=10, ARM_TIMEOUT=20, PULSE_CYC=4, KEY=8'hA5.
- Nominal: req_i=2'b10 rises; A5 key given 3 cycles later at edge j -> src_o=1; restart_n_o low exactly at edges j+10..j+13, high at j+14; state goes to LOCK until req_i=0, then IDLE.
- Arbitration and edge rules: req_i 00->11 in one cycle -> src_o=0. Second rise while ARMED -> ignored. Held-high req after LOCK->IDLE -> no re-arm.
- Wrong key / timeout: key 8'h5A -> IDLE, err_o=1, no pulse. Separately, no key for 20 cycles -> IDLE, err_o=1. err_clr_i clears it; set+clear in the same cycle -> err_o stays 1.
- Abort: abort_i in ARMED -> IDLE. abort_i at HOLD counter=5 -> IDLE, no pulse. abort_i together with a valid key in ARMED -> abort wins. abort_i in FIRE -> pulse still completes at 4 cycles.
- Reset mid-operation: RESETn low during FIRE cycle 2 -> restart_n_o=1 asynchronously, state_o=0, busy_o=0. After release, no pulse without a new rising edge.
- Back-to-back: complete a sequence, release req, re-request -> second full sequence with identical timing.
